gpu_cmd_queue: RTL

Command buffer between the SLC-3 datapath/ISDU and the graphics unit.
- Captures graphics commands issued by the CPU, together with operand snapshots of R0/R1/R2, into a FIFO.
- Hands the commands one at a time to the graphics unit over a two-phase toggle req/ack handshake.
- Lets the CPU keep executing while the graphics unit draws. The CPU stalls only when the queue is full.

---
 rtl/gpu_cmd_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_queue.sv
// Command FIFO between the SLC-3 ISDU and the graphics unit, issuing one command at a time over a toggle req/ack handshake.
// Optional ack timeout enabled by defining GPU_CMD_TIMEOUT_EN.
module gpu_cmd_queue #(
  parameter int DEPTH       = 8,
  parameter int CMD_W       = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      Clk,
  input  logic                      Reset_ah,
  input  logic                      cpu_valid,
  input  logic [CMD_W-1:0]          cpu_cmd,
  input  logic [DATA_W-1:0]         cpu_data,
  input  logic [9:0]                cpu_x,
  input  logic [9:0]                cpu_y,
  input  logic [7:0]                cpu_color,
  output logic                      cpu_full,
  output logic [$clog2(DEPTH):0]    cpu_count,
  output logic                      overflow,
  output logic [CMD_W-1:0]          gpu_command,
  output logic [DATA_W-1:0]         gpu_data,
  output logic [9:0]                gpu_x,
  output logic [9:0]                gpu_y,
  output logic [7:0]                gpu_color,
  output logic                      gpu_req,
  input  logic                      gpu_ack,
  output logic                      idle,
  output logic                      timeout_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int ENT_W = CMD_W + DATA_W + 28;
  localparam logic [CMD_W-1:0] CMD_FLUSH = {CMD_W{1'b1}};
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  state_e            state_q;
  logic [ENT_W-1:0]  gpu_ent_q;
  logic              gpu_req_q;
  logic              flush_s, pop_s, full_s, push_s, refuse_s, timeout_s;

  // Decode the push/pop/flush events for this edge.
  always_comb begin
    flush_s  = cpu_valid && (cpu_cmd == CMD_FLUSH);
    full_s   = (count_q == DEPTH_C);
    pop_s    = (state_q == S_IDLE) && (count_q != {CW{1'b0}});
    push_s   = cpu_valid && !flush_s && !full_s;
    refuse_s = cpu_valid && !flush_s && full_s;
  end

  // FIFO pointer, occupancy and overflow next-state; a flush overrides any pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_s) begin
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      if (push_s && !pop_s)      count_d = count_q + CW'(1);
      else if (!push_s && pop_s) count_d = count_q - CW'(1);
      else                       count_d = count_q;
      if (refuse_s) overflow_d = 1'b1;
      else          overflow_d = overflow_q;
    end
  end

  // FIFO control registers.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are meaningless once the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (push_s) mem_q[wr_ptr_q] <= {cpu_cmd, cpu_data, cpu_x, cpu_y, cpu_color};
  end

`ifdef GPU_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] to_cnt_q;
  logic          timeout_err_q;

  // The TIMEOUT_CYC-th unanswered WAIT cycle abandons the command.
  always_comb begin
    timeout_s = (state_q == S_WAIT) && (gpu_ack != gpu_req_q) && (to_cnt_q == TO_LAST);
  end

  // WAIT-cycle counter and sticky timeout flag.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      to_cnt_q      <= {TW{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE)  to_cnt_q <= {TW{1'b0}};
      else                    to_cnt_q <= to_cnt_q + TW'(1);
      if (timeout_s) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // Without the timeout option WAIT lasts until the ack arrives.
  always_comb begin
    timeout_s = 1'b0;
  end

  assign timeout_err = 1'b0;
`endif

  // Issue FSM with registered handshake and command outputs.
  always_ff @(posedge Clk or posedge Reset_ah) begin
    if (Reset_ah) begin
      state_q   <= S_IDLE;
      gpu_ent_q <= {ENT_W{1'b0}};
      gpu_req_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            gpu_ent_q <= mem_q[rd_ptr_q];
            gpu_req_q <= ~gpu_req_q;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (gpu_ack == gpu_req_q) begin
            state_q <= S_IDLE;
          end else if (timeout_s) begin
            gpu_req_q <= gpu_ack;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {gpu_command, gpu_data, gpu_x, gpu_y, gpu_color} = gpu_ent_q;
  assign gpu_req   = gpu_req_q;
  assign cpu_count = count_q;
  assign cpu_full  = full_s;
  assign overflow  = overflow_q;
  assign idle      = (state_q == S_IDLE) && (count_q == {CW{1'b0}});

endmodule
